// File: rtl/boundary_feeder.sv
// boundary_feeder
//   Producer for the boundary row memory's write port. Builds 40-bit river
//   boundary rows and hands each one over on datain with a single toggle of
//   shift (one toggle = one row written at the memory's write base).
//   After reset it prefills ROWS rows. After that it emits `speed` rows for
//   each accepted vsync_tick, which scrolls the river.
//
//   Row format: {left[39:30], right[29:20], isl_left[19:10], isl_right[9:0]}
//
//   Optional feature macro: BOUNDARY_ISLAND_EN. When it is defined, wide river
//   sections get a centred island. When it is undefined, both island fields
//   are always 0.
//
// Ports
//   clk          in   1   clock
//   reset        in   1   synchronous, active-high
//   enable       in   1   scroll run; low ignores vsync_tick and clears backlog
//   vsync_tick   in   1   one-cycle pulse per frame
//   speed        in   3   rows requested per accepted tick
//   seed         in   16  LFSR seed, sampled during reset (0 selects 16'hACE1)
//   shift        out  1   row strobe, toggles once per row (never reset)
//   datain       out  40  row data for the memory
//   prefill_done out  1   high once the ROWS prefill rows have been sent
//   busy         out  1   high whenever the row FSM is not idle
//   rows_emitted out  16  wrapping count of shift toggles since reset
module boundary_feeder #(
  parameter int ROWS        = 480,
  parameter int HOLD        = 3,
  parameter int CENTER_MIN  = 192,
  parameter int HALF_MIN    = 64,
  parameter int INIT_CENTER = 320,
  parameter int INIT_HALF   = 96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        vsync_tick,
  input  logic [2:0]  speed,
  input  logic [15:0] seed,
  output logic        shift,
  output logic [39:0] datain,
  output logic        prefill_done,
  output logic        busy,
  output logic [15:0] rows_emitted
);

  localparam int PW = $clog2(ROWS + 1);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_SEND, S_HOLD} state_t;

  state_t          state_reg, state_next;
  logic [HW-1:0]   hold_cnt_reg;
  logic [9:0]      centre_reg, half_reg, tgt_centre_reg, tgt_half_reg;
  logic [15:0]     lfsr_reg, lfsr_adv;
  logic [PW-1:0]   prefill_cnt_reg;
  logic [3:0]      pending_reg, pending_next;
  logic [4:0]      pending_sum;
  logic            prefill_done_reg, shift_reg;
  logic [39:0]     datain_reg, row_word;
  logic [15:0]     rows_emitted_reg;
  logic [9:0]      left_x, right_x;
  logic            hold_last, more_rows, at_target, accept, consume;

  // Galois LFSR, shifting right, with taps 16'hB400.
  assign lfsr_adv = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);

  assign left_x  = centre_reg - half_reg;
  assign right_x = centre_reg + half_reg;

`ifdef BOUNDARY_ISLAND_EN
  logic [9:0] inner_half, isl_left, isl_right;
  // An island appears only when the channel is wide enough to leave 64 px
  // of water on each side of it.
  always_comb begin
    inner_half = half_reg - 10'd64;
    isl_left   = 10'd0;
    isl_right  = 10'd0;
    if (half_reg >= 10'd96) begin
      isl_left  = centre_reg - inner_half;
      isl_right = centre_reg + inner_half;
    end
  end
  assign row_word = {left_x, right_x, isl_left, isl_right};
`else
  assign row_word = {left_x, right_x, 20'd0};
`endif

  assign hold_last = (hold_cnt_reg == HW'(HOLD - 1));
  assign more_rows = (!prefill_done_reg && (prefill_cnt_reg < PW'(ROWS))) || (pending_reg != 4'd0);
  assign at_target = (centre_reg == tgt_centre_reg) && (half_reg == tgt_half_reg);
  assign accept    = enable && prefill_done_reg && vsync_tick;
  assign consume   = (state_reg == S_SEND) && prefill_done_reg;

  // Backlog update. A tick and a SEND in the same cycle both take effect
  // before saturation. The floor at 0 covers a row that was already in
  // flight when enable dropped.
  always_comb begin
    pending_sum = {1'b0, pending_reg} + (accept ? {2'b00, speed} : 5'd0);
    if (consume && (pending_sum != 5'd0)) begin
      pending_sum = pending_sum - 5'd1;
    end
    pending_next = (pending_sum > 5'd15) ? 4'd15 : pending_sum[3:0];
    if (!enable) begin
      pending_next = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_GEN;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (pending_reg != 4'd0) state_next = S_GEN;
      S_GEN:  state_next = S_SEND;
      S_SEND: state_next = S_HOLD;
      S_HOLD: if (hold_last) state_next = more_rows ? S_GEN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      datain_reg       <= 40'd0;
      prefill_done_reg <= 1'b0;
      rows_emitted_reg <= 16'd0;
      pending_reg      <= 4'd0;
      centre_reg       <= 10'(INIT_CENTER);
      half_reg         <= 10'(INIT_HALF);
      tgt_centre_reg   <= 10'(INIT_CENTER);
      tgt_half_reg     <= 10'(INIT_HALF);
      prefill_cnt_reg  <= '0;
      lfsr_reg         <= (seed == 16'd0) ? 16'hACE1 : seed;
      hold_cnt_reg     <= '0;
    end else begin
      pending_reg <= pending_next;
      if (state_reg == S_HOLD) hold_cnt_reg <= hold_cnt_reg + HW'(1);
      else                     hold_cnt_reg <= '0;

      if (state_reg == S_GEN) begin
        datain_reg <= row_word;
        if (at_target) begin
          // On the target-draw cycle, nothing moves. The drift toward the
          // new target starts on the next row.
          lfsr_reg       <= lfsr_adv;
          tgt_centre_reg <= 10'(CENTER_MIN) + {2'b00, lfsr_adv[7:0]};
          tgt_half_reg   <= 10'(HALF_MIN) + {4'b0000, lfsr_adv[13:8]};
        end else begin
          if (centre_reg < tgt_centre_reg)      centre_reg <= centre_reg + 10'd1;
          else if (centre_reg > tgt_centre_reg) centre_reg <= centre_reg - 10'd1;
          if (half_reg < tgt_half_reg)          half_reg <= half_reg + 10'd1;
          else if (half_reg > tgt_half_reg)     half_reg <= half_reg - 10'd1;
        end
      end

      if (state_reg == S_SEND) begin
        rows_emitted_reg <= rows_emitted_reg + 16'd1;
        if (!prefill_done_reg) begin
          prefill_cnt_reg <= prefill_cnt_reg + PW'(1);
          if (prefill_cnt_reg == PW'(ROWS - 1)) prefill_done_reg <= 1'b1;
        end
      end
    end
  end

  // shift is deliberately left out of reset. Keeping its level means the
  // memory never sees a spurious edge when the feeder restarts.
  always_ff @(posedge clk) begin
    if (!reset && (state_reg == S_SEND)) shift_reg <= ~shift_reg;
  end

  assign shift        = shift_reg;
  assign datain       = datain_reg;
  assign prefill_done = prefill_done_reg;
  assign busy         = (state_reg != S_IDLE);
  assign rows_emitted = rows_emitted_reg;

endmodule
